bus_gate_arbiter: RTL and testbench
===================================

Name: bus_gate_arbiter

Overview:
Sequencer/arbiter for the shared 16-bit datapath bus. The bus has four tri-state sources (ALU, PC, MARMUX, MDR), and each source is enabled by its gate signal.
- Takes per-source bus requests and grants the bus to one source at a time.
- Drives the four gate signals as registered one-hot-or-zero outputs, so bus contention is impossible by construction.
- Sits between requesting control logic and the bus mux gate inputs.

Parameters:
- HOLD_MAX, 4: maximum consecutive cycles one owner may hold the bus per tenure. Legal range 1..15.
- TURN_CYCLES, 1: all-gates-off turnaround cycles inserted between tenures. Legal range 0..3.

Ports:
- Clk  in  1  system clock. All state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req  in  4  bus requests. Bit 0 = ALU, 1 = PC, 2 = MARMUX, 3 = MDR.
- GateALU  out  1  bus gate for the ALU source.
- GatePC  out  1  bus gate for the PC source.
- GateMARMUX  out  1  bus gate for the MARMUX source.
- GateMDR  out  1  bus gate for the MDR source.
- owner  out  2  index of the current or last owner.
- busy  out  1  high while any gate is high.
- tenure_done  out  1  one-cycle pulse on the cycle a tenure ends. The owner output is valid with the pulse.

Behaviour:
- Reset low (async):
  - state = IDLE.
  - All gates = 0, busy = 0, tenure_done = 0.
  - owner = 0, rr_ptr = 0, hold_cnt = 0.
  - Gates drop immediately, even mid-tenure.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req != 0, pick the first set bit at or after rr_ptr, wrapping modulo 4.
  - Next edge: go to GRANT, that source's gate = 1, owner = winner, hold_cnt = 1.
  - Latency: req sampled at edge k → gate high after edge k.
- GRANT:
  - Each edge, hold_cnt increments while req[owner] = 1 and hold_cnt < HOLD_MAX.
  - Tenure ends on the edge where req[owner] = 0 is sampled, or when hold_cnt = HOLD_MAX. The HOLD_MAX check forces release even if the owner still requests.
  - At tenure end:
    - gate drops;
    - tenure_done pulses for one cycle;
    - rr_ptr = owner + 1 (mod 4).
  - If TURN_CYCLES > 0: go to TURN.
  - If TURN_CYCLES = 0: arbitrate on the same edge from the new rr_ptr and hand off directly. The old gate falls and the new gate rises on the same edge; go to IDLE if no requests.
- TURN:
  - All gates 0 for exactly TURN_CYCLES cycles.
  - Then arbitrate as in IDLE. A waiting request is granted on the edge that ends TURN; with no requests, go to IDLE.
- No preemption. A higher-index request never interrupts a tenure.
- A released owner that re-requests competes normally. With rr_ptr advanced, it is last in the rotation. As the sole requester, it is re-granted after TURN.
- Requests that rise and fall entirely within GRANT or TURN are not latched and are lost. Requesters must hold req until they are granted.
- Invariant: at most one gate is high in every cycle. busy = OR of the gates.
- hold_cnt width is 4 bits, so HOLD_MAX = 15 never wraps.

Optional Feature:
BUS_ARB_FIXED_PRIORITY_EN
- Defined: round-robin is replaced by fixed priority MDR > MARMUX > PC > ALU, and rr_ptr is unused. HOLD_MAX and TURN_CYCLES still apply. Lower sources may starve.
- Undefined: round-robin arbitration as described above.

Decomposition:
- Package bus_arb_pkg:
  - NUM_SRC = 4;
  - src_e enum {SRC_ALU = 0, SRC_PC, SRC_MARMUX, SRC_MDR};
  - arb_state_e enum {IDLE, GRANT, TURN}.
- Sub-module rr_pick: combinational. Inputs req[3:0] and ptr[1:0]; outputs valid and idx[1:0]. It also hosts the fixed-priority variant under the macro.
- The top level holds the FSM, counters and registered gate decode.

Test Plan:
- Reset low while GatePC = 1 → all gates 0 in the same cycle; after release, owner = 0, busy = 0.
- Defaults; req = 0010 for 2 cycles, then 0 → GatePC high 2 cycles, tenure_done pulses once with owner = 1, then 1 turnaround cycle with gates 0, then IDLE.
- Defaults; req = 1111 held → grant order ALU, PC, MARMUX, MDR, ALU. Each tenure is 4 cycles, separated by 1 idle cycle (period 20). Never two gates high.
- Defaults; req = 1000 held 12 cycles → GateMDR 4 on, 1 off, 4 on, 1 off, 2 on. hold_cnt never exceeds 4.
- TURN_CYCLES = 0; req = 0110 held → GatePC 4 cycles, then GateMARMUX rises on the same edge GatePC falls, with no overlap.
- BUS_ARB_FIXED_PRIORITY_EN defined; req = 1111 held → GateMDR granted every tenure; GateALU never asserts.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus gate arbiter.
// Build option BUS_ARB_FIXED_PRIORITY_EN selects fixed priority in rr_pick.
package bus_arb_pkg;

  localparam int NUM_SRC = 4;

  typedef enum logic [1:0] {
    SRC_ALU    = 2'd0,
    SRC_PC     = 2'd1,
    SRC_MARMUX = 2'd2,
    SRC_MDR    = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  function automatic logic [NUM_SRC-1:0] src_onehot(input logic [1:0] idx);
    logic [NUM_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_gate_arbiter_rr_pick.sv
// Combinational winner selection: first request at or after ptr, wrapping.
// With BUS_ARB_FIXED_PRIORITY_EN defined, the highest index wins and ptr is ignored.
module rr_pick
  import bus_arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         ptr,
  output logic               valid,
  output logic [1:0]         idx
);

`ifdef BUS_ARB_FIXED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Later iterations overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i]) idx = 2'(i);
    end
  end
`else
  logic       found;
  logic [1:0] cand;

  always_comb begin
    valid = |req;
    idx   = '0;
    found = 1'b0;
    cand  = ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/bus_gate_arbiter.sv
// Bus gate sequencer: grants the shared bus to one source per tenure with registered one-hot gates.
// Build option BUS_ARB_FIXED_PRIORITY_EN swaps round-robin for fixed MDR > MARMUX > PC > ALU.
module bus_gate_arbiter
  import bus_arb_pkg::*;
#(
  parameter int HOLD_MAX    = 4,
  parameter int TURN_CYCLES = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] req,
  output logic       GateALU,
  output logic       GatePC,
  output logic       GateMARMUX,
  output logic       GateMDR,
  output logic [1:0] owner,
  output logic       busy,
  output logic       tenure_done
);

  arb_state_e         state;
  logic [NUM_SRC-1:0] gates;
  logic [1:0]         rr_ptr;
  logic [3:0]         hold_cnt;
  logic [1:0]         turn_cnt;
  logic [1:0]         pick_ptr;
  logic               pick_valid;
  logic [1:0]         pick_idx;

  // During GRANT the picker already looks from owner+1 so a zero-turnaround handoff sees the advanced pointer.
  assign pick_ptr = (state == GRANT) ? owner + 2'd1 : rr_ptr;

  rr_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      gates       <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
      turn_cnt    <= '0;
      tenure_done <= 1'b0;
    end else begin
      tenure_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= GRANT;
            gates    <= src_onehot(pick_idx);
            owner    <= pick_idx;
            hold_cnt <= 4'd1;
          end
        end
        GRANT: begin
          if (req[owner] && (hold_cnt < 4'(HOLD_MAX))) begin
            hold_cnt <= hold_cnt + 4'd1;
          end else begin
            tenure_done <= 1'b1;
            rr_ptr      <= owner + 2'd1;
            gates       <= '0;
            hold_cnt    <= '0;
            if (TURN_CYCLES > 0) begin
              state    <= TURN;
              turn_cnt <= 2'd1;
            end else if (pick_valid) begin
              state    <= GRANT;
              gates    <= src_onehot(pick_idx);
              owner    <= pick_idx;
              hold_cnt <= 4'd1;
            end else begin
              state <= IDLE;
            end
          end
        end
        TURN: begin
          if (turn_cnt >= 2'(TURN_CYCLES)) begin
            turn_cnt <= '0;
            if (pick_valid) begin
              state    <= GRANT;
              gates    <= src_onehot(pick_idx);
              owner    <= pick_idx;
              hold_cnt <= 4'd1;
            end else begin
              state <= IDLE;
            end
          end else begin
            turn_cnt <= turn_cnt + 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          gates <= '0;
        end
      endcase
    end
  end

  assign GateALU    = gates[SRC_ALU];
  assign GatePC     = gates[SRC_PC];
  assign GateMARMUX = gates[SRC_MARMUX];
  assign GateMDR    = gates[SRC_MDR];
  assign busy       = |gates;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Self-checking bench for bus_gate_arbiter: default instance plus a zero-turnaround instance.
// Expectations follow BUS_ARB_FIXED_PRIORITY_EN when the bench is built with it.
module tb_bus_gate_arbiter;

  logic       Clk;
  logic       Reset;
  logic [3:0] req;
  logic [3:0] req0;

  logic       GateALU, GatePC, GateMARMUX, GateMDR, busy, tenure_done;
  logic [1:0] owner;
  logic       GateALU0, GatePC0, GateMARMUX0, GateMDR0, busy0, tenure_done0;
  logic [1:0] owner0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gates;
    logic [1:0] owner;
    logic       td;
  } vec_t;

  vec_t tbl [14];

  bus_gate_arbiter dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .req         (req),
    .GateALU     (GateALU),
    .GatePC      (GatePC),
    .GateMARMUX  (GateMARMUX),
    .GateMDR     (GateMDR),
    .owner       (owner),
    .busy        (busy),
    .tenure_done (tenure_done)
  );

  bus_gate_arbiter #(.HOLD_MAX(4), .TURN_CYCLES(0)) dut0 (
    .Clk         (Clk),
    .Reset       (Reset),
    .req         (req0),
    .GateALU     (GateALU0),
    .GatePC      (GatePC0),
    .GateMARMUX  (GateMARMUX0),
    .GateMDR     (GateMDR0),
    .owner       (owner0),
    .busy        (busy0),
    .tenure_done (tenure_done0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [3:0] gv();
    return {GateMDR, GateMARMUX, GatePC, GateALU};
  endfunction

  function automatic logic [3:0] gv0();
    return {GateMDR0, GateMARMUX0, GatePC0, GateALU0};
  endfunction

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive both request vectors at the falling edge, then return at the next falling edge.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] r0);
    req  = r;
    req0 = r0;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    logic [3:0] expG;
    logic       expTd;

    tbl[0]  = '{4'b0010, 4'b0010, 2'd1, 1'b0};
    tbl[1]  = '{4'b0010, 4'b0010, 2'd1, 1'b0};
    tbl[2]  = '{4'b0000, 4'b0000, 2'd1, 1'b1};
    tbl[3]  = '{4'b0000, 4'b0000, 2'd1, 1'b0};
    tbl[4]  = '{4'b0001, 4'b0001, 2'd0, 1'b0};
    tbl[5]  = '{4'b0101, 4'b0001, 2'd0, 1'b0};
    tbl[6]  = '{4'b0100, 4'b0000, 2'd0, 1'b1};
    tbl[7]  = '{4'b0100, 4'b0100, 2'd2, 1'b0};
    tbl[8]  = '{4'b0000, 4'b0000, 2'd2, 1'b1};
    tbl[9]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
    tbl[10] = '{4'b0010, 4'b0010, 2'd1, 1'b0};
    tbl[11] = '{4'b0011, 4'b0010, 2'd1, 1'b0};
    tbl[12] = '{4'b0001, 4'b0000, 2'd1, 1'b1};
    tbl[13] = '{4'b0000, 4'b0000, 2'd1, 1'b0};

    Reset = 1'b0;
    req   = '0;
    req0  = '0;
    repeat (2) @(negedge Clk);
    checkOutput("reset_state", {gv(), owner, busy, tenure_done}, 8'h00);
    Reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].req, 4'b0000);
      checkOutput($sformatf("vec%0d", i), {gv(), owner, busy, tenure_done},
                  {tbl[i].gates, tbl[i].owner, |tbl[i].gates, tbl[i].td});
    end

    // Sole MDR requester held 12 cycles: hold limit forces release and re-grant after the turnaround.
    for (int t = 0; t < 12; t++) begin
      applyStimulus(4'b1000, 4'b0000);
      expTd = (t == 4) || (t == 9);
      checkOutput($sformatf("mdr_hold%0d", t), {3'b000, tenure_done, GateMDR, busy, owner},
                  {3'b000, expTd, ~expTd, ~expTd, 2'd3});
    end
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("mdr_release", {gv(), owner, busy, tenure_done}, {4'b0000, 2'd3, 1'b0, 1'b1});
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("mdr_idle", {gv(), busy, tenure_done}, 8'h00);

    // All four requesting: rotation with 4-cycle tenures and one dead cycle between them.
    for (int t = 0; t < 25; t++) begin
      applyStimulus(4'b1111, 4'b0000);
`ifdef BUS_ARB_FIXED_PRIORITY_EN
      expG = ((t % 5) < 4) ? 4'b1000 : 4'b0000;
`else
      expG = ((t % 5) < 4) ? oh((t / 5) % 4) : 4'b0000;
`endif
      expTd = ((t % 5) == 4);
      checkOutput($sformatf("all_req%0d", t), {3'b000, expTd, gv()}, {3'b000, tenure_done, expG});
    end
    applyStimulus(4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("all_req_idle", {gv(), busy, tenure_done}, 8'h00);

    // Zero-turnaround instance: old gate falls and new gate rises on the same edge.
    for (int t = 0; t < 9; t++) begin
      applyStimulus(4'b0000, 4'b0110);
`ifdef BUS_ARB_FIXED_PRIORITY_EN
      expG = 4'b0100;
`else
      expG = (t < 4 || t == 8) ? 4'b0010 : 4'b0100;
`endif
      expTd = (t == 4) || (t == 8);
      checkOutput($sformatf("turn0_%0d", t), {3'b000, tenure_done0, gv0()}, {3'b000, expTd, expG});
    end
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("turn0_release", {3'b000, tenure_done0, gv0()}, 8'h10);

    // Asynchronous reset in the middle of a PC tenure.
    applyStimulus(4'b0010, 4'b0000);
    checkOutput("pre_reset_pc", {7'd0, GatePC}, 8'h01);
    #2 Reset = 1'b0;
    #1 checkOutput("async_reset_gates", {gv(), busy, tenure_done, 2'b00}, 8'h00);
    req = '0;
    @(negedge Clk);
    Reset = 1'b1;
    #1 checkOutput("post_reset_state", {owner, busy, gv(), 1'b0}, 8'h00);
    @(negedge Clk);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("post_reset_idle", {gv(), owner, busy, tenure_done}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
